hi_tag_manchester_decoder: RTL and testbench

HI_TAG_MANCHESTER_DECODER -- requirements
Module: hi_tag_manchester_decoder

---
 rtl/hi_tag_decoder_pkg.sv | 9 +
 rtl/hi_amp_slicer.sv | 19 +
 rtl/hi_tag_manchester_decoder.sv | 185 ++++++++++++++++++
 tb/tb_hi_tag_manchester_decoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hi_tag_decoder_pkg.sv
// hi_tag_decoder_pkg: shared types and constants for the HITAG Manchester decoder
package hi_tag_decoder_pkg;
  typedef enum logic [1:0] {IDLE, FIRST_HALF, SECOND_HALF, FLUSH} state_t;
  localparam logic [1:0] HB_MOD_UNMOD = 2'b10;
  localparam logic [1:0] HB_UNMOD_MOD = 2'b01;
  localparam logic [1:0] HB_COLL      = 2'b11;
  localparam logic [1:0] HB_EOF       = 2'b00;
  localparam int AMP_W_DEF = 14;
endpackage

// File: rtl/hi_amp_slicer.sv
// hi_amp_slicer: hysteresis slicer turning correlator amplitude into the modulation level
module hi_amp_slicer import hi_tag_decoder_pkg::*; #(
  parameter int AMP_W = AMP_W_DEF
) (
  input  logic             adc_clk,
  input  logic             rst_n,
  input  logic             amp_valid,
  input  logic [AMP_W-1:0] amp,
  input  logic [AMP_W-1:0] thresh_hi,
  input  logic [AMP_W-1:0] thresh_lo,
  output logic             mod_nxt
);
  logic mod_q, mod_d;
  always_comb mod_d = !amp_valid ? mod_q : (amp > thresh_hi) ? 1'b1 : (amp < thresh_lo) ? 1'b0 : mod_q;
  assign mod_nxt = mod_d;
  always_ff @(negedge adc_clk or negedge rst_n)
    if (!rst_n) mod_q <= 1'b0;
    else mod_q <= mod_d;
endmodule

// File: rtl/hi_tag_manchester_decoder.sv
// hi_tag_manchester_decoder: sliced half-bit pairs to characters with SOF/EOF framing.
// HI_TAG_DECODER_PARITY_EN adds a 9th odd-parity bit per character.
module hi_tag_manchester_decoder import hi_tag_decoder_pkg::*; #(
  parameter int AMP_W     = AMP_W_DEF,
  parameter int MAX_BYTES = 64
) (
  input  logic             adc_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             amp_valid,
  input  logic [AMP_W-1:0] amp,
  input  logic [AMP_W-1:0] thresh_hi,
  input  logic [AMP_W-1:0] thresh_lo,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic [3:0]       byte_bits,
  output logic             parity_err,
  output logic             collision,
  output logic             frame_end,
  output logic             overflow
);
`ifdef HI_TAG_DECODER_PARITY_EN
  localparam int CHAR_W = 9;
  logic perr_q, perr_d, e_perr;
`else
  localparam int CHAR_W = 8;
`endif
  localparam int CHR_W = $clog2(MAX_BYTES + 1);

  state_t            state_q, state_d;
  logic              half_q, half_d, sof_q, sof_d, coll_q, coll_d;
  logic [CHAR_W-1:0] sr_q, sr_d, sr_ins;
  logic [3:0]        cnt_q, cnt_d, bits_q, bits_d, e_bits;
  logic [CHR_W-1:0]  chars_q, chars_d;
  logic [7:0]        data_q, data_d, e_data;
  logic              bv_q, bv_d, fe_q, fe_d, ovf_q, ovf_d, cout_q, cout_d;
  logic              mod_nxt, data_bit, full, emit, e_coll;
  logic [1:0]        pair;

  hi_amp_slicer #(.AMP_W(AMP_W)) u_slicer (
    .adc_clk(adc_clk), .rst_n(rst_n), .amp_valid(amp_valid), .amp(amp),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .mod_nxt(mod_nxt)
  );

  assign pair     = {half_q, mod_nxt};
  assign data_bit = (pair == HB_MOD_UNMOD) || (pair == HB_COLL);
  assign sr_ins   = sr_q | (CHAR_W'(data_bit) << cnt_q);
  assign full     = cnt_q == 4'(CHAR_W - 1);

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    sof_d   = sof_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    coll_d  = coll_q;
    chars_d = chars_q;
    data_d  = data_q;
    bits_d  = bits_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    emit    = 1'b0;
    e_data  = sr_ins[7:0];
    e_bits  = 4'd8;
    e_coll  = coll_q | (pair == HB_COLL);
`ifdef HI_TAG_DECODER_PARITY_EN
    perr_d  = perr_q;
    e_perr  = 1'b0;
`endif
    case (state_q)
      IDLE: if (amp_valid && mod_nxt) begin
        state_d = SECOND_HALF;
        half_d  = 1'b1;
        sof_d   = 1'b1;
        sr_d    = '0;
        cnt_d   = '0;
        coll_d  = 1'b0;
        chars_d = '0;
      end
      FIRST_HALF: if (amp_valid) begin
        half_d  = mod_nxt;
        state_d = SECOND_HALF;
      end
      SECOND_HALF: if (amp_valid) begin
        if (pair == HB_EOF) begin
          state_d = FLUSH;
          emit    = cnt_q != 4'd0;
          e_data  = sr_q[7:0];
          e_bits  = cnt_q;
          e_coll  = coll_q;
        end else begin
          state_d = FIRST_HALF;
          sof_d   = 1'b0;
          if (!sof_q && full) begin
            emit   = 1'b1;
            sr_d   = '0;
            cnt_d  = '0;
            coll_d = 1'b0;
`ifdef HI_TAG_DECODER_PARITY_EN
            e_perr = ~^sr_ins;
`endif
          end else if (!sof_q) begin
            sr_d   = sr_ins;
            cnt_d  = cnt_q + 4'd1;
            coll_d = e_coll;
          end
        end
      end
      FLUSH: begin
        fe_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    // a character past MAX_BYTES is dropped and terminates the frame on the spot
    if (emit && chars_q == CHR_W'(MAX_BYTES)) begin
      ovf_d   = 1'b1;
      fe_d    = 1'b1;
      state_d = IDLE;
    end else if (emit) begin
      bv_d    = 1'b1;
      chars_d = chars_q + 1'b1;
      data_d  = e_data;
      bits_d  = e_bits;
      cout_d  = e_coll;
`ifdef HI_TAG_DECODER_PARITY_EN
      perr_d  = e_perr;
`endif
    end
    if (!enable) begin
      state_d = IDLE;
      bv_d    = 1'b0;
      fe_d    = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(negedge adc_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      half_q  <= 1'b0;
      sof_q   <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
      chars_q <= '0;
      data_q  <= '0;
      bits_q  <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      sof_q   <= sof_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
      chars_q <= chars_d;
      data_q  <= data_d;
      bits_q  <= bits_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end

`ifdef HI_TAG_DECODER_PARITY_EN
  always_ff @(negedge adc_clk or negedge rst_n)
    if (!rst_n) perr_q <= 1'b0;
    else perr_q <= perr_d;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign byte_valid = bv_q;
  assign byte_data  = data_q;
  assign byte_bits  = bits_q;
  assign collision  = cout_q;
  assign frame_end  = fe_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_hi_tag_manchester_decoder.sv
// tb_hi_tag_manchester_decoder: scoreboard bench; expected strobes are queued as frames are sent
module tb_hi_tag_manchester_decoder;
  localparam int AMP_W = 14;
  localparam int HI = 400;
  localparam int LO = 100;

  typedef struct packed {
    logic       fe;
    logic [7:0] data;
    logic [3:0] bits;
    logic       perr;
    logic       coll;
  } ev_t;

  logic             adc_clk, rst_n, enable, amp_valid;
  logic [AMP_W-1:0] amp, thresh_hi, thresh_lo;
  logic             byte_valid, parity_err, collision, frame_end, overflow;
  logic [7:0]       byte_data;
  logic [3:0]       byte_bits;
  ev_t              evq[$];
  int               n_chk = 0;
  int               n_err = 0;

  hi_tag_manchester_decoder #(.AMP_W(AMP_W), .MAX_BYTES(2)) dut (
    .adc_clk(adc_clk), .rst_n(rst_n), .enable(enable), .amp_valid(amp_valid), .amp(amp),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_bits(byte_bits), .parity_err(parity_err), .collision(collision),
    .frame_end(frame_end), .overflow(overflow)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge adc_clk)
    if (byte_valid || frame_end) begin
      ev_t e;
      if (evq.size() == 0) check("unexpected_strobe", {30'd0, byte_valid, frame_end}, 32'd0);
      else begin
        e = evq.pop_front();
        check("frame_end", {31'd0, frame_end}, {31'd0, e.fe});
        check("byte_valid", {31'd0, byte_valid}, {31'd0, !e.fe});
        if (!e.fe) begin
          check("byte_data", {24'd0, byte_data}, {24'd0, e.data});
          check("byte_bits", {28'd0, byte_bits}, {28'd0, e.bits});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
          check("collision", {31'd0, collision}, {31'd0, e.coll});
        end
      end
    end

  task automatic exp_byte(input logic [7:0] d, input logic [3:0] b, input logic p, input logic c);
    evq.push_back('{fe: 1'b0, data: d, bits: b, perr: p, coll: c});
  endtask

  task automatic exp_fe();
    evq.push_back('{fe: 1'b1, data: 8'd0, bits: 4'd0, perr: 1'b0, coll: 1'b0});
  endtask

  task automatic send_half(input int a);
    @(posedge adc_clk);
    amp = AMP_W'(a);
    amp_valid = 1'b1;
    @(posedge adc_clk);
    amp_valid = 1'b0;
    repeat (3) @(posedge adc_clk);
  endtask

  task automatic send_bit(input logic b);
    send_half(b ? HI : LO);
    send_half(b ? LO : HI);
  endtask

  task automatic send_coll();
    send_half(HI);
    send_half(HI);
  endtask

  task automatic send_eof();
    send_half(LO);
    send_half(LO);
    repeat (4) @(posedge adc_clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [7:0] cm);
    for (int i = 0; i < 8; i++)
      if (cm[i]) send_coll();
      else send_bit(d[i]);
`ifdef HI_TAG_DECODER_PARITY_EN
    send_bit(~^(d | cm));
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bv"}, {31'd0, byte_valid}, 32'd0);
    check({tag, "_data"}, {24'd0, byte_data}, 32'd0);
    check({tag, "_bits"}, {28'd0, byte_bits}, 32'd0);
    check({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
    check({tag, "_coll"}, {31'd0, collision}, 32'd0);
    check({tag, "_fe"}, {31'd0, frame_end}, 32'd0);
    check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
  endtask

  task automatic overflow_frame();
    exp_byte(8'h11, 4'd8, 1'b0, 1'b0);
    exp_byte(8'h22, 4'd8, 1'b0, 1'b0);
    exp_fe();
    send_bit(1'b1);
    send_byte(8'h11, 8'h00);
    send_byte(8'h22, 8'h00);
    send_byte(8'h33, 8'h00);
    send_eof();
    check("overflow_set", {31'd0, overflow}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    amp_valid = 1'b0;
    amp = '0;
    thresh_hi = AMP_W'(300);
    thresh_lo = AMP_W'(200);
    repeat (3) @(posedge adc_clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge adc_clk);

    exp_byte(8'h55, 4'd8, 1'b0, 1'b0);
    exp_fe();
    send_bit(1'b1);
    send_byte(8'h55, 8'h00);
    send_eof();

    exp_byte(8'hA3, 4'd8, 1'b0, 1'b0);
    exp_byte(8'h05, 4'd3, 1'b0, 1'b0);
    exp_fe();
    send_bit(1'b1);
    send_byte(8'hA3, 8'h00);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_eof();
    repeat (10) @(posedge adc_clk);
    check("hold_data", {24'd0, byte_data}, 32'h05);
    check("hold_bits", {28'd0, byte_bits}, 32'd3);

    exp_byte(8'h07, 4'd3, 1'b0, 1'b1);
    exp_fe();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_coll();
    send_eof();

    exp_byte(8'h04, 4'd8, 1'b0, 1'b1);
    exp_byte(8'h3C, 4'd8, 1'b0, 1'b0);
    exp_fe();
    send_bit(1'b1);
    send_byte(8'h00, 8'h04);
    send_byte(8'h3C, 8'h00);
    send_eof();

    exp_fe();
    send_half(310);
    send_half(250);
    send_half(190);
    send_half(250);
    repeat (4) @(posedge adc_clk);

    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    enable = 1'b0;
    repeat (3) @(posedge adc_clk);
    enable = 1'b1;
    repeat (3) @(posedge adc_clk);
    exp_byte(8'h81, 4'd8, 1'b0, 1'b0);
    exp_fe();
    send_bit(1'b1);
    send_byte(8'h81, 8'h00);
    send_eof();

`ifdef HI_TAG_DECODER_PARITY_EN
    exp_byte(8'h01, 4'd8, 1'b1, 1'b0);
    exp_fe();
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(i == 0);
    send_bit(1'b1);
    send_eof();
    exp_byte(8'h01, 4'd8, 1'b0, 1'b0);
    exp_fe();
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(i == 0);
    send_bit(1'b0);
    send_eof();
`endif

    overflow_frame();
    exp_byte(8'h44, 4'd8, 1'b0, 1'b0);
    exp_fe();
    send_bit(1'b1);
    send_byte(8'h44, 8'h00);
    send_eof();
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("overflow_rst", {31'd0, overflow}, 32'd0);
    repeat (2) @(posedge adc_clk);
    rst_n = 1'b1;
    repeat (2) @(posedge adc_clk);

    overflow_frame();
    enable = 1'b0;
    repeat (2) @(posedge adc_clk);
    check("overflow_enable", {31'd0, overflow}, 32'd0);
    enable = 1'b1;
    repeat (2) @(posedge adc_clk);

    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_half(HI);
    @(posedge adc_clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    repeat (2) @(posedge adc_clk);
    rst_n = 1'b1;
    repeat (2) @(posedge adc_clk);
    exp_byte(8'h9C, 4'd8, 1'b0, 1'b0);
    exp_fe();
    send_bit(1'b1);
    send_byte(8'h9C, 8'h00);
    send_eof();

    repeat (10) @(posedge adc_clk);
    check("pending_events", evq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
